// File: rtl/mem_dma.sv
// Byte block-copy initiator for the 256x8 memory get/set port: READ, CAPTURE, WRITE per byte.
// Optional MEM_DMA_FILL_EN adds a fill port that writes a constant pattern at one byte per cycle.
module mem_dma (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] src,
  input  logic [7:0] dst,
  input  logic [7:0] len,
`ifdef MEM_DMA_FILL_EN
  input  logic       fill,
`endif
  output logic [7:0] mem_addr,
  output logic [7:0] mem_val,
  output logic       mem_get,
  output logic       mem_set,
  input  logic [7:0] mem_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t     r_state, w_state_next;
  logic [7:0] r_src_ptr, w_src_ptr_next;
  logic [7:0] r_dst_ptr, w_dst_ptr_next;
  logic [7:0] r_len, w_len_next;
  logic [7:0] r_count, w_count_next;
  logic [7:0] r_mem_addr, w_mem_addr_next;
  logic [7:0] r_mem_val, w_mem_val_next;
  logic       r_mem_get, w_mem_get_next;
  logic       r_mem_set, w_mem_set_next;
  logic       r_busy, w_busy_next;
  logic       r_done, w_done_next;
  logic       r_fill, w_fill_next;
  logic       w_fill_in;
  logic [7:0] w_count_inc;

`ifdef MEM_DMA_FILL_EN
  assign w_fill_in = fill;
`else
  assign w_fill_in = 1'b0;
`endif

  assign w_count_inc = r_count + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_src_ptr  <= 8'd0;
      r_dst_ptr  <= 8'd0;
      r_len      <= 8'd0;
      r_count    <= 8'd0;
      r_mem_addr <= 8'd0;
      r_mem_val  <= 8'd0;
      r_mem_get  <= 1'b0;
      r_mem_set  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fill     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_src_ptr  <= w_src_ptr_next;
      r_dst_ptr  <= w_dst_ptr_next;
      r_len      <= w_len_next;
      r_count    <= w_count_next;
      r_mem_addr <= w_mem_addr_next;
      r_mem_val  <= w_mem_val_next;
      r_mem_get  <= w_mem_get_next;
      r_mem_set  <= w_mem_set_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_fill     <= w_fill_next;
    end
  end

  // Outputs are registered, so each branch computes what the bus shows in the state being entered.
  always_comb begin
    w_state_next    = r_state;
    w_src_ptr_next  = r_src_ptr;
    w_dst_ptr_next  = r_dst_ptr;
    w_len_next      = r_len;
    w_count_next    = r_count;
    w_mem_addr_next = r_mem_addr;
    w_mem_val_next  = r_mem_val;
    w_mem_get_next  = 1'b0;
    w_mem_set_next  = 1'b0;
    w_busy_next     = 1'b0;
    w_done_next     = 1'b0;
    w_fill_next     = r_fill;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_src_ptr_next = src;
          w_dst_ptr_next = dst;
          w_len_next     = len;
          w_count_next   = 8'd0;
          w_fill_next    = w_fill_in;
          if (len == 8'd0) begin
            w_state_next = S_DONE;
            w_done_next  = 1'b1;
          end else if (w_fill_in) begin
            w_state_next    = S_WRITE;
            w_mem_set_next  = 1'b1;
            w_mem_addr_next = dst;
            w_mem_val_next  = src;
            w_busy_next     = 1'b1;
          end else begin
            w_state_next    = S_READ;
            w_mem_get_next  = 1'b1;
            w_mem_addr_next = src;
            w_busy_next     = 1'b1;
          end
        end
      end

      S_READ: begin
        w_state_next = S_CAPTURE;
        w_busy_next  = 1'b1;
      end

      S_CAPTURE: begin
        w_state_next    = S_WRITE;
        w_mem_set_next  = 1'b1;
        w_mem_addr_next = r_dst_ptr;
        w_mem_val_next  = mem_out;
        w_busy_next     = 1'b1;
      end

      S_WRITE: begin
        w_src_ptr_next = r_src_ptr + 8'd1;
        w_dst_ptr_next = r_dst_ptr + 8'd1;
        w_count_next   = w_count_inc;
        if (w_count_inc == r_len) begin
          w_state_next = S_DONE;
          w_done_next  = 1'b1;
        end else if (r_fill) begin
          // Fill keeps the pattern already sitting in the write-data register.
          w_state_next    = S_WRITE;
          w_mem_set_next  = 1'b1;
          w_mem_addr_next = r_dst_ptr + 8'd1;
          w_busy_next     = 1'b1;
        end else begin
          w_state_next    = S_READ;
          w_mem_get_next  = 1'b1;
          w_mem_addr_next = r_src_ptr + 8'd1;
          w_busy_next     = 1'b1;
        end
      end

      S_DONE: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign mem_addr = r_mem_addr;
  assign mem_val  = r_mem_val;
  assign mem_get  = r_mem_get;
  assign mem_set  = r_mem_set;
  assign busy     = r_busy;
  assign done     = r_done;
  assign count    = r_count;

endmodule

// File: tb/tb_mem_dma.sv
// Directed plus randomized bench for mem_dma against a 256x8 memory and an array-level copy model.
module tb_mem_dma;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] src, dst, len;
  logic [7:0] mem_addr, mem_val, mem_out, count;
  logic       mem_get, mem_set, busy, done;
`ifdef MEM_DMA_FILL_EN
  logic       fill;
`endif

  always #5 clk = ~clk;

  mem_dma dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
`ifdef MEM_DMA_FILL_EN
    .fill(fill),
`endif
    .mem_addr(mem_addr), .mem_val(mem_val), .mem_get(mem_get), .mem_set(mem_set),
    .mem_out(mem_out), .busy(busy), .done(done), .count(count)
  );

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] rd_q [$];
  logic [7:0] wa_q [$];
  int n_done = 0;
  int n_clash = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Memory with registered read, plus a log of every strobe the DMA drives.
  always @(posedge clk) begin
    if (mem_set) mem[mem_addr] <= mem_val;
    if (mem_get) mem_out <= mem[mem_addr];
    if (mem_get) rd_q.push_back(mem_addr);
    if (mem_set) wa_q.push_back(mem_addr);
    if (done === 1'b1) n_done <= n_done + 1;
    if (mem_get && mem_set) n_clash <= n_clash + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload_rand();
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom_range(0, 255));
      mem[i] <= v;
      ref_mem[i] = v;
    end
    #0;
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic wait_done(inout int lat);
    while (done !== 1'b1 && lat < 1000) begin
      tick();
      lat++;
    end
  endtask

  // One complete copy transfer, checked against the array model and the expected strobe sequence.
  task automatic do_copy(input string tag, input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    int lat, d0, bad;
    logic [7:0] a;
    rd_q.delete();
    wa_q.delete();
    d0 = n_done;
    for (int i = 0; i < int'(l); i++) ref_mem[8'(d + i)] = ref_mem[8'(s + i)];
    src = s; dst = d; len = l; start = 1'b1;
`ifdef MEM_DMA_FILL_EN
    fill = 1'b0;
`endif
    tick();
    start = 1'b0;
    lat = 1;
    wait_done(lat);
    check({tag, "_latency"}, lat, (l == 0) ? 1 : 3 * int'(l) + 1);
    check({tag, "_count"}, count, l);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_nreads"}, rd_q.size(), l);
    check({tag, "_nwrites"}, wa_q.size(), l);
    bad = 0;
    for (int i = 0; i < int'(l); i++) begin
      a = 8'(s + i);
      if (i >= rd_q.size() || rd_q[i] !== a) bad++;
      a = 8'(d + i);
      if (i >= wa_q.size() || wa_q[i] !== a) bad++;
    end
    check({tag, "_addr_seq"}, bad, 0);
    check_mem({tag, "_mem"});
    tick();
    check({tag, "_done_1cyc"}, done, 1'b0);
    check({tag, "_done_pulses"}, n_done - d0, 1);
  endtask

  initial begin
    int lat, d0;
    rst = 1'b1; start = 1'b0; src = 8'd0; dst = 8'd0; len = 8'd0;
`ifdef MEM_DMA_FILL_EN
    fill = 1'b0;
`endif
    preload_rand();
    tick();
    tick();
    check("rst_addr", mem_addr, 8'd0);
    check("rst_val", mem_val, 8'd0);
    check("rst_get", mem_get, 1'b0);
    check("rst_set", mem_set, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_count", count, 8'd0);
    rst = 1'b0;
    tick();

    // Directed copy of a known pattern.
    mem[8'h10] <= 8'hAA; mem[8'h11] <= 8'hBB; mem[8'h12] <= 8'hCC; mem[8'h13] <= 8'hDD;
    ref_mem[8'h10] = 8'hAA; ref_mem[8'h11] = 8'hBB; ref_mem[8'h12] = 8'hCC; ref_mem[8'h13] = 8'hDD;
    tick();
    do_copy("copy4", 8'h10, 8'h80, 8'd4);
    check("copy4_b0", mem[8'h80], 8'hAA);
    check("copy4_b3", mem[8'h83], 8'hDD);

    do_copy("zero_len", 8'h10, 8'h50, 8'd0);
    do_copy("wrap", 8'hFE, 8'h01, 8'd4);
    do_copy("overlap", 8'h20, 8'h22, 8'd6);

    // A second start during a transfer, then another in the DONE cycle, are both ignored.
    preload_rand();
    for (int i = 0; i < 3; i++) ref_mem[8'h90 + i] = ref_mem[8'h10 + i];
    rd_q.delete();
    wa_q.delete();
    d0 = n_done;
    src = 8'h10; dst = 8'h90; len = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    for (int i = 0; i < 4; i++) begin tick(); lat++; end
    src = 8'h20; dst = 8'hA0; len = 8'd2; start = 1'b1;
    tick();
    lat++;
    start = 1'b0;
    wait_done(lat);
    check("busy_start_latency", lat, 10);
    check("busy_start_nwrites", wa_q.size(), 3);
    check_mem("busy_start_mem");
    src = 8'h30; dst = 8'hB0; len = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    check("done_start_busy", busy, 1'b0);
    check("done_start_get", mem_get, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("done_start_pulses", n_done - d0, 1);
    check("done_start_nwrites", wa_q.size(), 3);

    // Reset lands on the edge that would open byte 2's WRITE cycle.
    preload_rand();
    for (int i = 0; i < 2; i++) ref_mem[8'hC0 + i] = ref_mem[8'h30 + i];
    wa_q.delete();
    d0 = n_done;
    src = 8'h30; dst = 8'hC0; len = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_addr", mem_addr, 8'd0);
    check("midrst_val", mem_val, 8'd0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_count", count, 8'd0);
    check("midrst_set", mem_set, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    check("midrst_done_pulses", n_done - d0, 0);
    check("midrst_nwrites", wa_q.size(), 2);
    check_mem("midrst_mem");
    do_copy("after_rst", 8'h00, 8'hE0, 8'd2);

    // Randomized copies, overlap and wrap included.
    for (int t = 0; t < 8; t++) begin
      preload_rand();
      do_copy($sformatf("rand%0d", t), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 20)));
    end

`ifdef MEM_DMA_FILL_EN
    preload_rand();
    for (int i = 0; i < 3; i++) ref_mem[8'h40 + i] = 8'h5A;
    rd_q.delete();
    d0 = n_done;
    src = 8'h5A; dst = 8'h40; len = 8'd3; fill = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    fill = 1'b0;
    lat = 1;
    wait_done(lat);
    check("fill_latency", lat, 4);
    check("fill_count", count, 8'd3);
    check("fill_reads", rd_q.size(), 0);
    check_mem("fill_mem");
    tick();
    check("fill_done_pulses", n_done - d0, 1);
`endif

    check("get_set_exclusive", n_clash, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
